// File: rtl/btb_pkg.sv
// Shared BTB definitions: index width, prediction-state encodings, update record and
// the update-controller state type.
package btb_pkg;

    localparam int unsigned BtbIdxBits = 7;

    localparam logic [1:0] StronglyNotTaken = 2'b00;
    localparam logic [1:0] WeaklyNotTaken   = 2'b01;
    localparam logic [1:0] WeaklyTaken      = 2'b10;
    localparam logic [1:0] StronglyTaken    = 2'b11;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        found;
    } btb_upd_t;

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StFlush
    } upd_state_e;

endpackage

// File: rtl/btb_upd_fifo.sv
// In-order update queue: up to two pushes (lane 1 first) and one pop per cycle.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       clear_i,
    input  logic                       push1_i,
    input  btb_upd_t                   data1_i,
    input  logic                       push2_i,
    input  btb_upd_t                   data2_i,
    input  logic                       pop_i,
    output btb_upd_t                   head_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    btb_upd_t        mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d, wptr_p1;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wptr_p1 = ptr_inc(wptr_q);
        wptr_d  = wptr_q;
        if (push1_i && push2_i) begin
            wptr_d = ptr_inc(wptr_p1);
        end else if (push1_i || push2_i) begin
            wptr_d = wptr_p1;
        end
        rptr_d  = pop_i ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q + CntW'(push1_i) + CntW'(push2_i) - CntW'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push1_i) begin
                mem_q[wptr_q] <= data1_i;
            end
            if (push2_i) begin
                mem_q[push1_i ? wptr_p1 : wptr_q] <= data2_i;
            end
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-side controller: serialises dual-lane branch updates onto one write port and
// runs the one-entry-per-cycle clear sweep after reset and on flush.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int unsigned QDepth  = 4,
    parameter int unsigned IdxBits = BtbIdxBits
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               upd_valid_1_i,
    input  logic [31:0]        upd_pc_1_i,
    input  logic [31:0]        upd_target_1_i,
    input  logic               upd_taken_1_i,
    input  logic               upd_found_1_i,
    input  logic               upd_valid_2_i,
    input  logic [31:0]        upd_pc_2_i,
    input  logic [31:0]        upd_target_2_i,
    input  logic               upd_taken_2_i,
    input  logic               upd_found_2_i,
    input  logic               flush_req_i,
    input  logic               btb_ready_i,
    output logic               wr_valid_o,
    output logic               wr_clear_o,
    output logic [IdxBits-1:0] wr_index_o,
    output logic [31:0]        wr_pc_o,
    output logic [31:0]        wr_target_o,
    output logic               wr_taken_o,
    output logic               wr_found_o,
    output logic               upd_stall_o,
    output logic               busy_o
);

    localparam int unsigned CntW = $clog2(QDepth + 1);

    upd_state_e      state_q, state_d;
    logic [IdxBits-1:0] idx_q, idx_d;
    logic [CntW-1:0] count;
    btb_upd_t        head, data1, data2;
    logic            fifo_clear, push1, push2, pop;

    assign data1 = '{pc: upd_pc_1_i, target: upd_target_1_i,
                     taken: upd_taken_1_i, found: upd_found_1_i};
    assign data2 = '{pc: upd_pc_2_i, target: upd_target_2_i,
                     taken: upd_taken_2_i, found: upd_found_2_i};

    btb_upd_fifo #(
        .Depth(QDepth)
    ) u_fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(fifo_clear),
        .push1_i(push1),
        .data1_i(data1),
        .push2_i(push2),
        .data2_i(data2),
        .pop_i  (pop),
        .head_o (head),
        .count_o(count)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fifo_clear  = 1'b0;
        push1       = 1'b0;
        push2       = 1'b0;
        pop         = 1'b0;
        wr_valid_o  = 1'b0;
        wr_clear_o  = 1'b0;
        wr_index_o  = '0;
        wr_pc_o     = '0;
        wr_target_o = '0;
        wr_taken_o  = 1'b0;
        wr_found_o  = 1'b0;
        upd_stall_o = 1'b1;
        busy_o      = 1'b0;
        unique case (state_q)
            StInit, StFlush: begin
                wr_valid_o = 1'b1;
                wr_clear_o = 1'b1;
                wr_index_o = idx_q;
                busy_o     = 1'b1;
                if (btb_ready_i) begin
                    if (idx_q == {IdxBits{1'b1}}) begin
                        state_d = StRun;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StRun: begin
                wr_valid_o  = (count != '0);
                wr_pc_o     = head.pc;
                wr_target_o = head.target;
                wr_taken_o  = head.taken;
                wr_found_o  = head.found;
                // Registered count only: the threshold leaves room for a full pair.
                upd_stall_o = (count > CntW'(QDepth - 2));
                if (flush_req_i) begin
                    state_d    = StFlush;
                    idx_d      = '0;
                    fifo_clear = 1'b1;
                end else begin
                    pop   = wr_valid_o && btb_ready_i;
                    push1 = !upd_stall_o && upd_valid_1_i;
                    push2 = !upd_stall_o && upd_valid_2_i;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StInit;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule
